// File: rtl/id_ex_stage_fifo.sv
// rtl/id_ex_stage_fifo.sv - DEPTH-entry elastic ID/EX buffer with valid/ready handshake
//
// Purpose: decouples decode from execute by up to DEPTH entries. Each entry
// carries a control field and a data field. flush kills every entry, freeze
// stalls both sides.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous kill of all entries
//   freeze              global stall: no push, no pop
//   in_valid/in_ready   decode-side handshake, in_ctrl/in_data entry fields
//   out_valid/out_ready execute-side handshake, out_ctrl/out_data head fields
//   occupancy           number of valid entries
//   stall_cnt/drop_cnt  statistics counters
//
// Optional feature: define ID_EX_FIFO_STATS_EN to build the statistics
// counters; otherwise stall_cnt and drop_cnt are tied to zero.

module id_ex_stage_fifo #(
   parameter int CTRL_W = 6,
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       freeze,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [CTRL_W-1:0] ctrl_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OCC_W-1:0]  occ;
   logic              full;
   logic              push;
   logic              pop;

   assign full      = (occ == OCC_W'(DEPTH));
   assign in_ready  = !full && !freeze;
   assign out_valid = (occ != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !freeze && !flush;
   assign occupancy = occ;

   // Head fields are masked so an empty buffer never leaks stale storage.
   assign out_ctrl = out_valid ? ctrl_mem[rd_ptr] : '0;
   assign out_data = out_valid ? data_mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as is; occupancy 0 already hides it.
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            ctrl_mem[wr_ptr] <= in_ctrl;
            data_mem[wr_ptr] <= in_data;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

`ifdef ID_EX_FIFO_STATS_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W:0]   drop_sum;

   // One spare bit catches overflow for saturation.
   assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(occ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         drop_q  <= '0;
      end else begin
         if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (flush) begin
            drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
         end
      end
   end

   assign stall_cnt = stall_q;
   assign drop_cnt  = drop_q;
`else
   assign stall_cnt = '0;
   assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_fifo.sv
// tb/tb_id_ex_stage_fifo.sv - scoreboard testbench for id_ex_stage_fifo

module tb_id_ex_stage_fifo;

   localparam int CTRL_W = 6;
   localparam int DATA_W = 128;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 16;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              freeze;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [OCC_W-1:0]  occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  drop_cnt;

   id_ex_stage_fifo #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t exp_q[$];
   int   exp_stall;
   int   exp_drop;
   int   n_checks;
   int   n_fail;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is just an ordered list of entries.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         exp_stall = 0;
         exp_drop  = 0;
      end else begin
         automatic int  sz   = exp_q.size();
         automatic bit  acc  = (sz < DEPTH) && !freeze;
         automatic bit  take = in_valid && acc && !flush;
         automatic bit  give = (sz > 0) && out_ready && !freeze && !flush;
         automatic ent_t e;
         if (in_valid && !acc && !flush && exp_stall < CNT_MAX) exp_stall++;
         if (flush) begin
            exp_drop = (exp_drop + sz > CNT_MAX) ? CNT_MAX : exp_drop + sz;
            exp_q.delete();
         end else begin
            if (give) void'(exp_q.pop_front());
            if (take) begin
               e.c = in_ctrl;
               e.d = in_data;
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor: compares DUT outputs with the scoreboard head on every falling edge.
   always @(negedge clk) begin
      chk("out_valid", out_valid, (exp_q.size() != 0));
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", in_ready, (exp_q.size() < DEPTH) && !freeze);
      if (exp_q.size() != 0) begin
         chk("out_ctrl", out_ctrl, exp_q[0].c);
         chk("out_data", out_data, exp_q[0].d);
      end else begin
         chk("out_ctrl_zero", out_ctrl, 0);
         chk("out_data_zero", out_data, 0);
      end
`ifdef ID_EX_FIFO_STATS_EN
      chk("stall_cnt", stall_cnt, exp_stall);
      chk("drop_cnt", drop_cnt, exp_drop);
`else
      chk("stall_cnt", stall_cnt, 0);
      chk("drop_cnt", drop_cnt, 0);
`endif
   end

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic frz, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      freeze    = frz;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      flush = 0; freeze = 0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1. reset state
      repeat (3) drive(0, 0, 0, 0, 0, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_occ", occupancy, 0);

      // 2. fill with A, B then drain in order
      drive(1, 6'h21, 128'hA, 0, 0, 0);
      drive(1, 6'h05, 128'hB, 0, 0, 0);
      chk("full_occ", occupancy, 2);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_data, 128'hA);
      drive(0, 0, 0, 1, 0, 0);
      chk("second_head", out_data, 128'hB);
      drive(0, 0, 0, 1, 0, 0);
      chk("drained_ctrl", out_ctrl, 0);

      // 3. streaming through wrapping pointers
      for (int i = 0; i < 8; i++) drive(1, CTRL_W'(i), DATA_W'(i), 1, 0, 0);
      chk("stream_occ", occupancy, 1);
      chk("stream_last", out_data, 7);
      drive(0, 0, 0, 1, 0, 0);

      // 4. flush on full buffer beats freeze and an incoming entry
      drive(1, 6'h21, 128'hA, 0, 0, 0);
      drive(1, 6'h05, 128'hB, 0, 0, 0);
      drive(1, 6'h3F, 128'hC, 1, 1, 1);
      chk("flush_occ", occupancy, 0);
      chk("flush_valid", out_valid, 0);
      drive(0, 0, 0, 0, 0, 0);

      // 5. freeze holds one entry for 3 cycles
      drive(1, 6'h11, 128'hD, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 6'h12, 128'hE, 1, 1, 0);
      chk("freeze_head", out_data, 128'hD);
      drive(0, 0, 0, 1, 0, 0);

      // 6. asynchronous reset between edges with two entries held
      drive(1, 6'h01, 128'h1, 0, 0, 0);
      drive(1, 6'h02, 128'h2, 0, 0, 0);
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_occ", occupancy, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_in_ready", in_ready, 1);
      #1 rst = 1'b0;
      drive(1, 6'h07, 128'h77, 0, 0, 0);
      chk("post_rst_head", out_data, 128'h77);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, CTRL_W'($urandom),
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 19) == 0);
      end
      drive(0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
